// File: rtl/aes_result_packer.sv
// Packs byte-wide AES results into DATA_WIDTH words behind a byte buffer that absorbs output-FIFO stalls.
// Optional status ports (overflow, drop_cnt) are enabled by defining AES_PACK_STATUS_EN.
module aes_result_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 16
`ifdef AES_PACK_STATUS_EN
   ,
   parameter int CNT_WIDTH  = 16
`endif
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [7:0]            i_byte_in,
   input  logic                  i_byte_vld,
   input  logic                  i_flush,
   input  logic                  i_data_full,
   output logic                  o_data_wr,
   output logic [DATA_WIDTH-1:0] o_data_dout,
   output logic                  o_busy
`ifdef AES_PACK_STATUS_EN
   ,
   output logic                  o_overflow,
   output logic [CNT_WIDTH-1:0]  o_drop_cnt
`endif
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int PTR_W  = $clog2(BUF_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic {S_COLLECT, S_EMIT} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [7:0]            r_buf [BUF_DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [LANE_W-1:0]     r_lane;
   logic [DATA_WIDTH-1:0] r_word;
   logic                  r_flush_pend;

   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_last_lane;
   logic w_flush_clr;
   logic w_flush_emit;
   logic w_emit;

   assign w_empty     = (r_count == '0);
   // Fullness is judged on the pre-pop count, so a full buffer drops even if it pops this cycle.
   assign w_push      = i_byte_vld && (r_count != CNT_W'(BUF_DEPTH));
   assign w_last_lane = (r_lane == LANE_W'(BYTES - 1));

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_COLLECT;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_COLLECT: begin
            if (!w_empty) begin
               if (w_last_lane) w_state_nxt = S_EMIT;
            end else if (r_flush_pend && (r_lane != '0)) begin
               w_state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            if (!i_data_full) w_state_nxt = S_COLLECT;
         end
      endcase
   end

   always_comb begin
      w_pop        = 1'b0;
      w_flush_clr  = 1'b0;
      w_flush_emit = 1'b0;
      w_emit       = 1'b0;
      case (r_state)
         S_COLLECT: begin
            w_pop        = !w_empty;
            w_flush_clr  = w_empty && r_flush_pend;
            w_flush_emit = w_flush_clr && (r_lane != '0);
         end
         S_EMIT: begin
            w_emit = !i_data_full;
         end
      endcase
      o_busy = !w_empty || (r_lane != '0) || (r_state == S_EMIT) || r_flush_pend;
   end

   always_ff @(posedge i_clock) begin
      if (w_push) r_buf[r_wptr] <= i_byte_in;
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_lane       <= '0;
         r_word       <= '0;
         r_flush_pend <= 1'b0;
         o_data_wr    <= 1'b0;
         o_data_dout  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

         if (w_pop) begin
            r_word[8*r_lane +: 8] <= r_buf[r_rptr];
            r_lane <= w_last_lane ? '0 : r_lane + LANE_W'(1);
         end else if (w_flush_emit) begin
            r_lane <= '0;
         end

         // A new flush request wins over clearing the one just serviced.
         if (i_flush)          r_flush_pend <= 1'b1;
         else if (w_flush_clr) r_flush_pend <= 1'b0;

         o_data_wr <= w_emit;
         if (w_emit) begin
            o_data_dout <= r_word;
            r_word      <= '0;
         end
      end
   end

`ifdef AES_PACK_STATUS_EN
   logic w_drop;
   assign w_drop = i_byte_vld && !w_push;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end else if (w_drop) begin
         o_overflow <= 1'b1;
         if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + CNT_WIDTH'(1);
      end
   end
`endif

endmodule
